framebuffer_scanout: RTL and testbench
======================================

# framebuffer_scanout

Reads the framebuffer in raster order and drives display timing: horizontal and vertical sync, data enable, and pixel data. It is the read side of the framebuffer; the triangle rasterizer is the write side. The block sits between the framebuffer read port and the display PHY (for example a VGA DAC or HDMI encoder). It outputs one pixel per `clk`, so `clk` is the pixel clock.

## Interface
Parameters:
- `DISPLAY_WIDTH`, 100: active pixels per line.
- `DISPLAY_HEIGHT`, 100: active lines per frame.
- `H_FRONT_PORCH`, 4 / `H_SYNC`, 8 / `H_BACK_PORCH`, 4: horizontal blanking widths, in pixels.
- `V_FRONT_PORCH`, 2 / `V_SYNC`, 2 / `V_BACK_PORCH`, 2: vertical blanking widths, in lines.
- `SYNC_ACTIVE_LOW`, 1: polarity of `hsync` and `vsync`.
- `RD_LATENCY`, 1: framebuffer read latency in cycles; must be 1 or more.
- `FRAMEBUFFER_DATA_BITS`, 16: pixel width (RGB565).
- `FRAMEBUFFER_SIZE`, `DISPLAY_WIDTH*DISPLAY_HEIGHT`: framebuffer depth.
- `FRAMEBUFFER_ADDR_BITS`, `$clog2(FRAMEBUFFER_SIZE)`: address width.

Ports:
- `clk` in 1: pixel clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fb_rd_en` out 1: read strobe; high at active counter positions.
- `fb_rd_addr` out `FRAMEBUFFER_ADDR_BITS`: read address.
- `fb_rd_data` in `FRAMEBUFFER_DATA_BITS`: read data, valid `RD_LATENCY` cycles after the address.
- `hsync` out 1: horizontal sync, aligned with the pixel outputs.
- `vsync` out 1: vertical sync, aligned with the pixel outputs.
- `de` out 1: data enable, high during active video; aligned with the pixel outputs.
- `pixel_data` out `FRAMEBUFFER_DATA_BITS`: pixel value; zero whenever `de` is 0.
- `frame_start` out 1: one-cycle pulse when the counters are at (0,0); counter-aligned, not delayed.
- `vblank` out 1: high while the vertical counter is `DISPLAY_HEIGHT` or more; counter-aligned. The rasterizer may use it to swap buffers.

## Operation
- Derived constants:
  - `H_TOTAL = DISPLAY_WIDTH + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH` (116 with defaults).
  - `V_TOTAL` is the vertical equivalent (106 with defaults).
- Counter `h` runs 0..`H_TOTAL-1` and wraps to 0. On each wrap, counter `v` increments; `v` wraps 0..`V_TOTAL-1`.
- Position (h,v) is active when `h < DISPLAY_WIDTH` and `v < DISPLAY_HEIGHT`.
- `hsync` is active when `DISPLAY_WIDTH + H_FRONT_PORCH <= h < DISPLAY_WIDTH + H_FRONT_PORCH + H_SYNC`.
- `vsync` is active for whole lines with `DISPLAY_HEIGHT + V_FRONT_PORCH <= v < DISPLAY_HEIGHT + V_FRONT_PORCH + V_SYNC`.
- Sync is active at the level given by `SYNC_ACTIVE_LOW` (low when 1) and inactive at the opposite level.
- Address generation uses an incrementing register, not a multiplier:
  - The address register increments after each active position.
  - It resets to 0 when the counters wrap to (0,0).
  - At (x,y) it equals `x + DISPLAY_WIDTH*y`.
  - The last active pixel reads address `FRAMEBUFFER_SIZE-1`.
  - The address never exceeds `FRAMEBUFFER_SIZE-1`.
- Outside the active region, `fb_rd_en` is 0 and `fb_rd_addr` holds its last value.
- Delay alignment:
  - The active flag, `hsync` and `vsync` pass through a delay line of `RD_LATENCY` stages, then an output register.
  - `fb_rd_data` is captured into the `pixel_data` register.
  - When the delayed active flag is 0, `pixel_data` is forced to 0.
- There is no other state machine; the counters define the state: ACTIVE, H_FP, H_SYNC, H_BP, and vertical blanking.

## Timing
- Reset values:
  - Counters h=0, v=0; address register 0; delay lines cleared.
  - `de`=0 and `pixel_data`=0.
  - `hsync` and `vsync` at their inactive level.
  - `fb_rd_addr`=0.
  - During reset, `fb_rd_en`=0, `frame_start`=0 and `vblank`=0.
- Cycle 0 is the first cycle after `rst` falls:
  - The counters are at (0,0).
  - `fb_rd_en`=1, `fb_rd_addr`=0, `frame_start`=1.
- Latency:
  - A position presented to the counters in cycle n appears on `de`, `hsync`, `vsync` and `pixel_data` in cycle `n + RD_LATENCY + 1`.
  - All four outputs are mutually aligned.
- Frame period is `H_TOTAL*V_TOTAL` cycles; `frame_start` recurs at this interval.
- Reset mid-frame:
  - The next cycle holds reset values.
  - In-flight pixels are discarded.
  - Scanning restarts at (0,0) with address 0.
- Simultaneous wrap of h and v takes v to 0, the address register to 0, and asserts `frame_start` in the same cycle.

## Test plan
- Reset and first pixel (defaults, memory model where `mem[a]=a`):
  - Release `rst` -> cycle 0 shows `fb_rd_addr`=0, `fb_rd_en`=1, `frame_start`=1.
  - `de`=1 with `pixel_data`=0x0000 at cycle 2.
  - `pixel_data`=0x0001 at cycle 3.
  - `de` falls at cycle 102.
- Horizontal sync:
  - `hsync` is low for output cycles 106..113 of line 0 and high otherwise.
  - Line 1 starts with `fb_rd_addr`=100 at cycle 116.
- Vertical blanking and wrap:
  - `vblank` rises at cycle 11600.
  - `vsync` is low for counter lines 102..103.
  - `frame_start` and `fb_rd_addr`=0 recur at cycle 12296.
  - The last address read in the frame is 9999.
- Read latency variant:
  - With `RD_LATENCY`=3, the first `de`/`pixel_data` appears at cycle 4.
  - Sync edges shift by the same two cycles relative to the default case.
- Reset mid-frame:
  - Assert `rst` for 1 cycle at cycle 5000 -> next cycle `de`=0 and `pixel_data`=0.
  - Scanning restarts: `frame_start`=1 and `fb_rd_addr`=0 on the first cycle after release.
- Blanking data:
  - Drive `fb_rd_data`=0xFFFF constantly -> `pixel_data`=0 whenever `de`=0 across a full frame.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - raster-order framebuffer reader with display timing generation
module framebuffer_scanout #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int H_FRONT_PORCH         = 4,
    parameter int H_SYNC                = 8,
    parameter int H_BACK_PORCH          = 4,
    parameter int V_FRONT_PORCH         = 2,
    parameter int V_SYNC                = 2,
    parameter int V_BACK_PORCH          = 2,
    parameter bit SYNC_ACTIVE_LOW       = 1'b1,
    parameter int RD_LATENCY            = 1,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             fb_rd_en,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_rd_addr,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             de,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
    output logic                             frame_start,
    output logic                             vblank
);

    localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = FRAMEBUFFER_ADDR_BITS;

    localparam logic [HW-1:0] H_ACT_END  = HW'(DISPLAY_WIDTH);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(DISPLAY_WIDTH + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SYNC_END = HW'(DISPLAY_WIDTH + H_FRONT_PORCH + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(DISPLAY_HEIGHT);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(DISPLAY_HEIGHT + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SYNC_END = VW'(DISPLAY_HEIGHT + V_FRONT_PORCH + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(FRAMEBUFFER_SIZE - 1);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] addr_hold;

    logic active;
    logic hs_pos;
    logic vs_pos;
    logic h_wrap;
    logic v_wrap;

    assign active = (h < H_ACT_END) && (v < V_ACT_END);
    assign hs_pos = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
    assign vs_pos = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);

    // addr_cnt is the address of the current position while active; addr_hold
    // keeps the last issued address so the bus stays quiet during blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            h         <= '0;
            v         <= '0;
            addr_cnt  <= '0;
            addr_hold <= '0;
        end else begin
            h <= h_wrap ? '0 : h + HW'(1);
            if (h_wrap) begin
                v <= v_wrap ? '0 : v + VW'(1);
            end
            if (h_wrap && v_wrap) begin
                addr_cnt <= '0;
            end else if (active) begin
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + AW'(1);
            end
            if (active) begin
                addr_hold <= addr_cnt;
            end
        end
    end

    assign fb_rd_en    = !rst && active;
    assign fb_rd_addr  = rst ? '0 : (active ? addr_cnt : addr_hold);
    assign frame_start = !rst && (h == '0) && (v == '0);
    assign vblank      = !rst && (v >= V_ACT_END);

    // Control flags ride alongside the memory read so they meet the data.
    logic [RD_LATENCY-1:0] act_dly;
    logic [RD_LATENCY-1:0] hs_dly;
    logic [RD_LATENCY-1:0] vs_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_dly    <= '0;
            hs_dly     <= '0;
            vs_dly     <= '0;
            de         <= 1'b0;
            hsync      <= SYNC_ACTIVE_LOW;
            vsync      <= SYNC_ACTIVE_LOW;
            pixel_data <= '0;
        end else begin
            act_dly[0] <= active;
            hs_dly[0]  <= hs_pos;
            vs_dly[0]  <= vs_pos;
            for (int i = 1; i < RD_LATENCY; i++) begin
                act_dly[i] <= act_dly[i-1];
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
            end
            de         <= act_dly[RD_LATENCY-1];
            hsync      <= hs_dly[RD_LATENCY-1] ^ SYNC_ACTIVE_LOW;
            vsync      <= vs_dly[RD_LATENCY-1] ^ SYNC_ACTIVE_LOW;
            pixel_data <= act_dly[RD_LATENCY-1] ? fb_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - scoreboard bench for framebuffer_scanout at read latencies 1 and 3
module tb_framebuffer_scanout;

    localparam int W     = 100;
    localparam int H     = 100;
    localparam int HT    = W + 4 + 8 + 4;
    localparam int VT    = H + 2 + 2 + 2;
    localparam int FRAME = HT * VT;
    localparam int SIZE  = W * H;
    localparam int RL0   = 1;
    localparam int RL1   = 3;
    localparam int NCYC  = 3 + 5001 + FRAME + 400;

    typedef struct {
        bit rd_en;
        int addr;
        bit fs;
        bit vb;
        bit de;
        bit hs;
        bit vs;
        int pix;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] mem [SIZE];

    logic [1:0]  rd_en;
    logic [13:0] rd_addr [2];
    logic [15:0] rd_data [2];
    logic [1:0]  hs;
    logic [1:0]  vs;
    logic [1:0]  de;
    logic [15:0] pix [2];
    logic [1:0]  fs;
    logic [1:0]  vb;

    framebuffer_scanout #(.RD_LATENCY(RL0)) dut0 (
        .clk(clk), .rst(rst),
        .fb_rd_en(rd_en[0]), .fb_rd_addr(rd_addr[0]), .fb_rd_data(rd_data[0]),
        .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .pixel_data(pix[0]),
        .frame_start(fs[0]), .vblank(vb[0])
    );

    framebuffer_scanout #(.RD_LATENCY(RL1)) dut1 (
        .clk(clk), .rst(rst),
        .fb_rd_en(rd_en[1]), .fb_rd_addr(rd_addr[1]), .fb_rd_data(rd_data[1]),
        .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .pixel_data(pix[1]),
        .frame_start(fs[1]), .vblank(vb[1])
    );

    // Memory returns all-ones when not strobed so blanking leakage is visible.
    function automatic logic [15:0] mem_rd(logic en, logic [13:0] a);
        if (en && int'(a) < SIZE) return mem[a];
        return 16'hFFFF;
    endfunction

    logic [15:0] pipe0;
    logic [15:0] pipe1 [RL1];
    always @(posedge clk) begin
        pipe0    <= mem_rd(rd_en[0], rd_addr[0]);
        pipe1[0] <= mem_rd(rd_en[1], rd_addr[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rd_data[0] = pipe0;
    assign rd_data[1] = pipe1[RL1-1];

    // k counts cycles since the last reset release; k==0 is the first free cycle.
    function automatic exp_t model(int rl, bit r, int k, int cyc);
        exp_t e;
        int p, x, y;
        p = k % FRAME;
        x = p % HT;
        y = p / HT;
        if (r) begin
            e.rd_en = 1'b0; e.addr = 0; e.fs = 1'b0; e.vb = 1'b0;
        end else begin
            e.rd_en = (x < W) && (y < H);
            e.fs    = (p == 0);
            e.vb    = (y >= H);
            if (e.rd_en)    e.addr = y * W + x;
            else if (y < H) e.addr = y * W + W - 1;
            else            e.addr = SIZE - 1;
        end
        if (k <= rl) begin
            e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.pix = 0;
        end else begin
            p = (k - rl - 1) % FRAME;
            x = p % HT;
            y = p / HT;
            e.de  = (x < W) && (y < H);
            e.hs  = !((x >= W + 4) && (x < W + 12));
            e.vs  = !((y >= H + 2) && (y < H + 4));
            e.pix = e.de ? int'(mem[y * W + x]) : 0;
        end
        e.cyc = cyc;
        return e;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, int inst, int cyc, int act, int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, inst, cyc, act, want);
        end
    endtask

    task automatic check_inst(int i, exp_t e);
        chk("fb_rd_en",    i, e.cyc, int'(rd_en[i]),   int'(e.rd_en));
        chk("fb_rd_addr",  i, e.cyc, int'(rd_addr[i]), e.addr);
        chk("frame_start", i, e.cyc, int'(fs[i]),      int'(e.fs));
        chk("vblank",      i, e.cyc, int'(vb[i]),      int'(e.vb));
        chk("de",          i, e.cyc, int'(de[i]),      int'(e.de));
        chk("hsync",       i, e.cyc, int'(hs[i]),      int'(e.hs));
        chk("vsync",       i, e.cyc, int'(vs[i]),      int'(e.vs));
        chk("pixel_data",  i, e.cyc, int'(pix[i]),     e.pix);
    endtask

    exp_t q0[$];
    exp_t q1[$];

    always @(negedge clk) begin
        if (q0.size() > 0) check_inst(0, q0.pop_front());
        if (q1.size() > 0) check_inst(1, q1.pop_front());
    end

    initial begin
        int  k;
        bit  prev_rst;
        bit  pulsed;
        bit  r;
        for (int i = 0; i < SIZE; i++) mem[i] = 16'($urandom);
        k        = 0;
        prev_rst = 1'b1;
        pulsed   = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            k = prev_rst ? 0 : k + 1;
            r = (c < 3);
            if (!r && !pulsed && k == 5000) begin
                r      = 1'b1;
                pulsed = 1'b1;
            end
            rst = r;
            q0.push_back(model(RL0, r, k, c));
            q1.push_back(model(RL1, r, k, c));
            prev_rst = r;
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 0, NCYC, q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
